// File: rtl/vga_pkg.sv
// Shared timing defaults and FSM state type for the VGA scan-out block.
package vga_pkg;

  // Default timing: 800x480 panel, porches and pulses in pixels / lines.
  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

  // Test pattern grid pitch is 2**PATTERN_PITCH_LOG2 pixels / lines.
  localparam int PATTERN_PITCH_LOG2 = 4;

  // SYNC: waiting for a frame boundary with a full FIFO. RUN: streaming.
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

  // Total period of one axis: front porch + pulse + back porch + active.
  function automatic int scan_total(input int fp, input int pulse,
                                    input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// One wrapping scan counter (0..TOTAL-1) with a terminal-count flag.
// Used once per axis; the vertical instance is enabled by the horizontal
// terminal count.
module scan_counter #(
  parameter int TOTAL = 1056,
  parameter int W     = $clog2(TOTAL)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == W'(TOTAL - 1));
  assign cnt_o = cnt_q;

  // Next count: hold when disabled, wrap to zero at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_scan.sv
// VGA scan-out: generates syncs from two wrapping counters and streams pixels
// from a show-ahead FIFO once it has aligned to a frame boundary with a full
// FIFO. Line/frame order is front porch, pulse, back porch, active.
// Optional macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces the
// FIFO stream with a white 16x16 grid.
//
// FIFO handshake: fifo_rdata is valid whenever fifo_rempty is low; asserting
// fifo_rinc for one cycle consumes exactly the word presented on that cycle,
// and that word is registered onto vga_rgb on the same edge.
module vga_scan
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int VDISP  = DEF_VDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_rempty,
  input  logic        fifo_rfull,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        fifo_rinc,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic [23:0] vga_rgb,
  output logic        vga_clk,
  output logic        underrun
);

  localparam int HTOTAL = scan_total(HFP, HPULSE, HBP, HDISP);
  localparam int VTOTAL = scan_total(VFP, VPULSE, VBP, VDISP);
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_ACT    = HW'(HTOTAL - HDISP);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_ACT    = VW'(VTOTAL - VDISP);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_tc;
  logic          v_tc;
  logic          active;
  logic          h_sync_n;
  logic          v_sync_n;

  scan_state_e   state_q;
  scan_state_e   state_d;
  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  logic          blank_d;
  logic [23:0]   rgb_q;
  logic [23:0]   rgb_d;
  logic          underrun_q;
  logic          underrun_d;

  // Alpha byte of the FIFO word carries no colour.
  logic unused_alpha;
  assign unused_alpha = ^fifo_rdata[31:24];

  scan_counter #(.TOTAL(HTOTAL), .W(HW)) u_hcnt (
    .clk_i (pixel_clk),
    .rst_i (pixel_rst),
    .en_i  (1'b1),
    .cnt_o (h_cnt),
    .tc_o  (h_tc)
  );

  scan_counter #(.TOTAL(VTOTAL), .W(VW)) u_vcnt (
    .clk_i (pixel_clk),
    .rst_i (pixel_rst),
    .en_i  (h_tc),
    .cnt_o (v_cnt),
    .tc_o  (v_tc)
  );

  assign active   = (h_cnt >= H_ACT) && (v_cnt >= V_ACT);
  assign h_sync_n = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
  assign v_sync_n = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));

`ifdef VGA_TEST_PATTERN_EN
  logic [HW-1:0] h_rel;
  logic [VW-1:0] v_rel;
  logic          grid_hit;
  assign h_rel    = h_cnt - H_ACT;
  assign v_rel    = v_cnt - V_ACT;
  assign grid_hit = (h_rel[PATTERN_PITCH_LOG2-1:0] == '0) ||
                    (v_rel[PATTERN_PITCH_LOG2-1:0] == '0);
`endif

  // Next state, pop request and next video values for the current counter.
  always_comb begin
    state_d    = state_q;
    fifo_rinc  = 1'b0;
    blank_d    = 1'b0;
    rgb_d      = '0;
    underrun_d = underrun_q;
    case (state_q)
      SYNC: begin
        if (h_tc && v_tc && fifo_rfull) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (active) begin
          blank_d = 1'b1;
          if (!fifo_rempty) begin
            fifo_rinc = 1'b1;
            rgb_d     = fifo_rdata[23:0];
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
`ifdef VGA_TEST_PATTERN_EN
    // Test pattern freezes the FSM and leaves the FIFO untouched.
    if (test_mode) begin
      state_d    = state_q;
      fifo_rinc  = 1'b0;
      underrun_d = underrun_q;
      blank_d    = active;
      rgb_d      = (active && grid_hit) ? 24'hFFFFFF : 24'h000000;
    end
`endif
    if (pixel_rst) begin
      fifo_rinc = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Video output registers: one cycle behind the counters, mutually aligned.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      hs_q       <= h_sync_n;
      vs_q       <= v_sync_n;
      blank_q    <= blank_d;
      rgb_q      <= rgb_d;
      underrun_q <= underrun_d;
    end
  end

  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign vga_blank = blank_q;
  assign vga_rgb   = rgb_q;
  assign underrun  = underrun_q;
  assign vga_clk   = pixel_clk;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan at HDISP=160, VDISP=90 (HTOTAL=288, VTOTAL=135).
// Inputs change just after the falling edge; registered outputs are sampled
// on the falling edge, fifo_rinc 1 time unit after inputs settle.
module tb_vga_scan;

  localparam int HT = 288;
  localparam int VT = 135;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdata;
  logic        rempty;
  logic        rfull;
  logic        rinc;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [23:0] rgb;
  logic        vclk;
  logic        und;

  int tests = 0;
  int fails = 0;

  // Bench copy of the scan position: h/v = counter now, ph/pv = at last edge.
  int h  = 0;
  int v  = 0;
  int ph = 0;
  int pv = 0;

  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  vga_scan #(.HDISP(160), .VDISP(90)) dut (
    .pixel_clk   (clk),
    .pixel_rst   (rst),
    .fifo_rdata  (rdata),
    .fifo_rempty (rempty),
    .fifo_rfull  (rfull),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (1'b0),
`endif
    .fifo_rinc   (rinc),
    .vga_hs      (hs),
    .vga_vs      (vs),
    .vga_blank   (blank),
    .vga_rgb     (rgb),
    .vga_clk     (vclk),
    .underrun    (und)
  );

  function automatic logic exp_hs(input int x);
    return !(x >= 40 && x < 88);
  endfunction

  function automatic logic exp_vs(input int y);
    return !(y >= 13 && y < 16);
  endfunction

  function automatic logic is_act(input int x, input int y);
    return (x >= 128) && (y >= 45);
  endfunction

  // One clock: advance the bench position model, end on the falling edge.
  task automatic step();
    @(posedge clk);
    ph = h;
    pv = v;
    if (rst) begin
      h = 0;
      v = 0;
    end else if (h == HT - 1) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
    @(negedge clk);
  endtask

  task automatic drive_pixel(input logic full, input logic empty);
    rfull  = full;
    rempty = empty;
    rdata  = (h == 128 && v == 45) ? 32'h00ABCDEF
                                   : {8'h5A, 7'd0, 9'(h), 8'(v)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_pixel(1'b1, 1'b0);
    repeat (3) step();
    #1;
    tests++; if (rinc !== 1'b0)  begin fails++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    tests++; if (hs !== 1'b1)    begin fails++; $display("FAIL reset_hs: got %b want 1", hs); end
    tests++; if (vs !== 1'b1)    begin fails++; $display("FAIL reset_vs: got %b want 1", vs); end
    tests++; if (blank !== 1'b0) begin fails++; $display("FAIL reset_blank: got %b want 0", blank); end
    tests++; if (rgb !== 24'h0)  begin fails++; $display("FAIL reset_rgb: got %h want 000000", rgb); end
    tests++; if (und !== 1'b0)   begin fails++; $display("FAIL reset_underrun: got %b want 0", und); end
    tests++; if (vclk !== clk)   begin fails++; $display("FAIL vga_clk: got %b want %b", vclk, clk); end
    rst = 1'b0;
  endtask

  // Frame 1: SYNC. rfull held low until line 100, so the only legal
  // transition is at the very end of the frame.
  task automatic test_sync_frame();
    int hs_err = 0, vs_err = 0, hs_low0 = 0, vs_low = 0;
    int blank_hi = 0, rgb_nz = 0, rinc_cnt = 0;
    for (int n = 0; n < HT * VT; n++) begin
      drive_pixel(logic'(v >= 100), 1'b0);
      #1;
      if (rinc !== 1'b0) rinc_cnt++;
      step();
      if (hs !== exp_hs(ph)) hs_err++;
      if (pv == 0 && hs === 1'b0) hs_low0++;
      if (vs !== exp_vs(pv)) vs_err++;
      if (vs === 1'b0) vs_low++;
      if (blank !== 1'b0) blank_hi++;
      if (rgb !== 24'h0) rgb_nz++;
    end
    tests++; if (hs_err != 0)   begin fails++; $display("FAIL sync_hs_timing: %0d bad cycles, want 0", hs_err); end
    tests++; if (hs_low0 != 48) begin fails++; $display("FAIL sync_hs_low: got %0d want 48", hs_low0); end
    tests++; if (vs_err != 0)   begin fails++; $display("FAIL sync_vs_timing: %0d bad cycles, want 0", vs_err); end
    tests++; if (vs_low != 864) begin fails++; $display("FAIL sync_vs_low: got %0d want 864", vs_low); end
    tests++; if (blank_hi != 0) begin fails++; $display("FAIL sync_blank: got %0d high, want 0", blank_hi); end
    tests++; if (rgb_nz != 0)   begin fails++; $display("FAIL sync_rgb: got %0d nonzero, want 0", rgb_nz); end
    tests++; if (rinc_cnt != 0) begin fails++; $display("FAIL sync_rinc: got %0d pops, want 0", rinc_cnt); end
  endtask

  // Frame 2: RUN. Underrun injected for 5 pixels at line 100, x=72..76.
  task automatic test_run_frame();
    int hs_err = 0, vs_err = 0, blank_err = 0, rgb_err = 0, rinc_err = 0;
    int pops = 0, pops46 = 0, und_px = 0, first_h = -1, first_v = -1;
    logic exp_rinc;
    for (int n = 0; n < HT * VT; n++) begin
      drive_pixel(1'b1, logic'(v == 100 && h >= 200 && h < 205));
      #1;
      exp_rinc = is_act(h, v) && !rempty;
      if (rinc !== exp_rinc) rinc_err++;
      if (rinc === 1'b1) begin
        pops++;
        if (v == 46) pops46++;
        if (first_h < 0) begin first_h = h; first_v = v; end
      end
      if (is_act(h, v)) begin
        if (rempty) begin und_px++; exp_q.push_back(24'h0); end
        else exp_q.push_back(rdata[23:0]);
      end
      step();
      if (hs !== exp_hs(ph)) hs_err++;
      if (vs !== exp_vs(pv)) vs_err++;
      if (blank !== is_act(ph, pv)) blank_err++;
      if (is_act(ph, pv)) begin
        if (exp_q.size() == 0) rgb_err++;
        else if (rgb !== exp_q.pop_front()) rgb_err++;
      end else if (rgb !== 24'h0) rgb_err++;
      if (ph == 128 && pv == 45) begin
        tests++; if (rgb !== 24'hABCDEF) begin fails++; $display("FAIL first_pixel_rgb: got %h want abcdef", rgb); end
        tests++; if (blank !== 1'b1) begin fails++; $display("FAIL first_pixel_blank: got %b want 1", blank); end
      end
      if (ph == 199 && pv == 100) begin
        tests++; if (und !== 1'b0) begin fails++; $display("FAIL underrun_early: got %b want 0", und); end
      end
    end
    tests++; if (first_h != 128)  begin fails++; $display("FAIL first_pop_h: got %0d want 128", first_h); end
    tests++; if (first_v != 45)   begin fails++; $display("FAIL first_pop_v: got %0d want 45", first_v); end
    tests++; if (pops46 != 160)   begin fails++; $display("FAIL pops_per_line: got %0d want 160", pops46); end
    tests++; if (pops != 14395)   begin fails++; $display("FAIL pops_per_frame: got %0d want 14395", pops); end
    tests++; if (und_px != 5)     begin fails++; $display("FAIL underrun_pixels: got %0d want 5", und_px); end
    tests++; if (und !== 1'b1)    begin fails++; $display("FAIL underrun_sticky: got %b want 1", und); end
    tests++; if (hs_err != 0)     begin fails++; $display("FAIL run_hs_timing: %0d bad cycles, want 0", hs_err); end
    tests++; if (vs_err != 0)     begin fails++; $display("FAIL run_vs_timing: %0d bad cycles, want 0", vs_err); end
    tests++; if (blank_err != 0)  begin fails++; $display("FAIL run_blank: %0d bad cycles, want 0", blank_err); end
    tests++; if (rgb_err != 0)    begin fails++; $display("FAIL run_rgb: %0d bad pixels, want 0", rgb_err); end
    tests++; if (rinc_err != 0)   begin fails++; $display("FAIL run_rinc: %0d bad cycles, want 0", rinc_err); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL run_queue: %0d left, want 0", exp_q.size()); end
  endtask

  // Frame 3, line 0: reset in the middle of the hsync pulse while in RUN.
  task automatic test_reset_mid();
    repeat (60) begin
      drive_pixel(1'b1, 1'b0);
      step();
    end
    tests++; if (hs !== 1'b0)  begin fails++; $display("FAIL pre_reset_hs: got %b want 0", hs); end
    tests++; if (und !== 1'b1) begin fails++; $display("FAIL underrun_held: got %b want 1", und); end
    rst = 1'b1;
    #1;
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL mid_reset_rinc: got %b want 0", rinc); end
    step();
    tests++; if (hs !== 1'b1)    begin fails++; $display("FAIL mid_reset_hs: got %b want 1", hs); end
    tests++; if (vs !== 1'b1)    begin fails++; $display("FAIL mid_reset_vs: got %b want 1", vs); end
    tests++; if (blank !== 1'b0) begin fails++; $display("FAIL mid_reset_blank: got %b want 0", blank); end
    tests++; if (rgb !== 24'h0)  begin fails++; $display("FAIL mid_reset_rgb: got %h want 000000", rgb); end
    tests++; if (und !== 1'b0)   begin fails++; $display("FAIL mid_reset_underrun: got %b want 0", und); end
    rst = 1'b0;
  endtask

  // After reset the FSM is back in SYNC: the first active pixels of the
  // restarted frame must not pop even with a full FIFO.
  task automatic test_post_reset();
    int hs_err = 0, blank_hi = 0, rinc_cnt = 0;
    for (int n = 0; n < 45 * HT + 141; n++) begin
      drive_pixel(1'b1, 1'b0);
      #1;
      if (rinc !== 1'b0) rinc_cnt++;
      step();
      if (hs !== exp_hs(ph)) hs_err++;
      if (blank !== 1'b0) blank_hi++;
    end
    tests++; if (hs_err != 0)   begin fails++; $display("FAIL post_reset_hs: %0d bad cycles, want 0", hs_err); end
    tests++; if (blank_hi != 0) begin fails++; $display("FAIL post_reset_blank: got %0d high, want 0", blank_hi); end
    tests++; if (rinc_cnt != 0) begin fails++; $display("FAIL post_reset_rinc: got %0d pops, want 0", rinc_cnt); end
  endtask

  initial begin
    rst    = 1'b1;
    rfull  = 1'b0;
    rempty = 1'b1;
    rdata  = 32'h0;
    @(negedge clk);
    test_reset();
    test_sync_frame();
    test_run_frame();
    test_reset_mid();
    test_post_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 SHALL have parameter HDISP, default 800, active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameters HFP=40, HPULSE=48, HBP=40, VFP=13, VPULSE=3, VBP=29 (defaults), porch/pulse lengths in pixels/lines.
REQ-004 SHALL have port pixel_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port pixel_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports fifo_rdata input 32 (show-ahead pixel, RGB in [23:0]), fifo_rempty input 1, fifo_rfull input 1.
REQ-007 SHALL have port fifo_rinc  output  1  pop request, combinational, one word per asserted cycle.
REQ-008 SHALL have ports vga_hs, vga_vs output 1 (active-low syncs), vga_blank output 1 (0 = blanked), vga_rgb output 24, vga_clk output 1 (= pixel_clk, forwarded).
REQ-009 SHALL have port underrun  output  1  sticky flag: active pixel requested while FIFO empty.

Function
REQ-010 hcnt SHALL count 0..HTOTAL-1, HTOTAL = HFP+HPULSE+HBP+HDISP; wrap to 0 and increment vcnt.
REQ-011 vcnt SHALL count 0..VTOTAL-1, VTOTAL = VFP+VPULSE+VBP+VDISP; wrap to 0 when hcnt wraps at vcnt=VTOTAL-1.
REQ-012 Line order SHALL be front porch, pulse, back porch, active; same for frame.
REQ-013 Counter widths SHALL be $clog2(HTOTAL) and $clog2(VTOTAL).
REQ-014 Active region SHALL be hcnt >= HTOTAL-HDISP and vcnt >= VTOTAL-VDISP.
REQ-015 vga_hs SHALL be 0 iff hcnt in [HFP, HFP+HPULSE); vga_vs SHALL be 0 iff vcnt in [VFP, VFP+VPULSE).
REQ-016 All video outputs SHALL be registered, 1-cycle latency from counter value; hs, vs, blank, rgb mutually aligned.
REQ-017 FSM states SHALL be SYNC and RUN.
REQ-018 SYNC: fifo_rinc=0, vga_blank=0, vga_rgb=0; syncs still generated.
REQ-019 SYNC->RUN SHALL occur only at hcnt=HTOTAL-1, vcnt=VTOTAL-1 with fifo_rfull=1; otherwise stay in SYNC.
REQ-020 RUN: fifo_rinc = active && !fifo_rempty; vga_rgb <= fifo_rdata[23:0] on the same edge.
REQ-021 RUN, active pixel with fifo_rempty=1: vga_rgb <= 0, vga_blank <= 1, fifo_rinc=0, underrun <= 1; stay in RUN (no realignment).
REQ-022 RUN SHALL be left only by reset.
REQ-023 Outside active region vga_blank=0, vga_rgb=0, fifo_rinc=0.

Reset
REQ-024 On pixel_rst=1: hcnt=0, vcnt=0, state=SYNC, vga_hs=1, vga_vs=1, vga_blank=0, vga_rgb=0, underrun=0.
REQ-025 Reset mid-frame SHALL abort at the next edge; fifo_rinc SHALL be 0 while pixel_rst=1.

Configuration
REQ-026 Macro VGA_TEST_PATTERN_EN SHALL add input test_mode (1 bit).
REQ-027 With macro and test_mode=1: fifo_rinc=0, FSM frozen, vga_rgb = 24'hFFFFFF when hcnt-(HTOTAL-HDISP) or vcnt-(VTOTAL-VDISP) is a multiple of 16, else 0, in active region with vga_blank=1; underrun unchanged.
REQ-028 Without macro: no test_mode port, no pattern logic.

Structure
REQ-029 Package vga_pkg SHALL hold default timing constants and the state enum (SYNC, RUN).
REQ-030 Sub-module scan_counter SHALL implement one wrapping counter with terminal-count output, instantiated for h and v.

Verification (HDISP=160, VDISP=90, HTOTAL=288, VTOTAL=135)
REQ-031 Reset, fifo_rfull=0 -> vga_hs low 48 cycles per 288-cycle period, vga_vs low 3 lines per 135 lines, vga_blank=0 throughout, fifo_rinc=0.
REQ-032 fifo_rfull=1, rempty=0 from reset -> first fifo_rinc at frame 2, hcnt=128, vcnt=45; exactly 160 pops per line, 14400 per frame.
REQ-033 fifo_rdata=32'h00ABCDEF popped -> vga_rgb=24'hABCDEF one cycle later with vga_blank=1.
REQ-034 RUN, rempty=1 for 5 active cycles -> vga_rgb=0 for 5 pixels, underrun=1 and held until reset; timing unchanged.
REQ-035 pixel_rst pulse mid-line in RUN -> next cycle all outputs at reset values, state SYNC.
REQ-036 VGA_TEST_PATTERN_EN, test_mode=1 -> white at active pixels x=0,16,... and lines y=0,16,...; fifo_rinc never asserted.
